// File: rtl/spi_byte_receiver.sv
// SPI byte receiver: synchronizes spi_clk/spi_data into clk, assembles MSB-first bytes
// and presents them on a valid/ready holding register with sticky overrun/frame errors.
module spi_byte_receiver #(
  parameter int IDLE_TIMEOUT = 32,
  parameter int TO_W         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk_in,
  input  logic       spi_data_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clr_err
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  logic            sclk_meta_q, sclk_s_q, sclk_q;
  logic            sdat_meta_q, sdat_s_q;
  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic            rise, byte_done, timeout, load;
  logic [7:0]      byte_next;

  assign rise      = sclk_s_q & ~sclk_q;
  assign byte_next = {shift_q[6:0], sdat_s_q};

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    byte_done = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        to_cnt_d  = '0;
        if (rise) begin
          shift_d   = byte_next;
          bit_cnt_d = 3'd1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          shift_d   = byte_next;
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // A rise in this cycle takes priority, so only a quiet threshold cycle times out.
          timeout   = 1'b1;
          bit_cnt_d = 3'd0;
          to_cnt_d  = '0;
          state_d   = IDLE;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Accepting the held byte in the completion cycle frees the register for the new one.
    load        = byte_done & (~rx_valid_q | rx_ready);
    rx_data_d   = load ? byte_next : rx_data_q;
    rx_valid_d  = load | (rx_valid_q & ~rx_ready);
    overrun_d   = (byte_done & ~load) | (overrun_q & ~clr_err);
    frame_err_d = timeout | (frame_err_q & ~clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta_q <= 1'b1;
      sclk_s_q    <= 1'b1;
      sclk_q      <= 1'b1;
      sdat_meta_q <= 1'b0;
      sdat_s_q    <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      to_cnt_q    <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_meta_q <= spi_clk_in;
      sclk_s_q    <= sclk_meta_q;
      sclk_q      <= sclk_s_q;
      sdat_meta_q <= spi_data_in;
      sdat_s_q    <= sdat_meta_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_byte_receiver.md
Name: spi_byte_receiver

Overview:
Downstream stage of the SPI byte transmitter: recovers bytes from the serial spi_clk/spi_data pair back into the system clock domain.
- Oversamples both lines on the 100 MHz system clock through 2-flop synchronizers and detects spi_clk rising edges.
- Assembles MSB-first bytes and presents each one on a valid/ready holding register.
- Flags overrun and mid-byte idle timeout (frame error).
- Used as the loopback checker and as the receive side of on-board SPI links.

Parameters:
IDLE_TIMEOUT, 32, system-clock cycles without a spi_clk rising edge, while mid-byte, before the partial byte is discarded
TO_W, 6, timeout counter width; must satisfy 2^TO_W > IDLE_TIMEOUT

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
spi_clk_in  input  1  serial clock from transmitter, idles high, asynchronous to clk
spi_data_in  input  1  serial data, changes on spi_clk falling edge, MSB first
rx_data  output  8  received byte, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready
overrun  output  1  sticky: a completed byte was dropped because the holding register was full
frame_err  output  1  sticky: idle timeout occurred with 1..7 bits received
clr_err  input  1  synchronous clear of overrun and frame_err

Behaviour:
- Reset values:
  - spi_clk synchronizer flops = 1; spi_data synchronizer flops = 0.
  - shift_reg = 0, bit_cnt = 0, to_cnt = 0, state = IDLE.
  - rx_data = 0x00, rx_valid = 0, overrun = 0, frame_err = 0.
- Reset mid-byte: partial byte lost; holding register emptied.
- Synchronizers: sclk_s and sdat_s are 2-stage synced. sclk_q is sclk_s delayed one cycle.
- rise = sclk_s & ~sclk_q. Falling edges are ignored.
- On a rise cycle, sdat_s is sampled in that same cycle.
- FSM states:
  - IDLE: bit_cnt=0, to_cnt held at 0.
    - On rise: shift_reg<={shift_reg[6:0],sdat_s}, bit_cnt<=1, go to SHIFT.
  - SHIFT: each cycle without rise, to_cnt increments.
    - On rise: shift in bit, to_cnt<=0, bit_cnt++.
    - If the bit taken is the 8th (bit_cnt==7 before the rise): the byte {shift_reg[6:0],sdat_s} completes, bit_cnt<=0, go to IDLE.
    - If to_cnt reaches IDLE_TIMEOUT-1 with no rise: bit_cnt<=0, frame_err<=1, go to IDLE; partial byte discarded.
- Byte completion:
  - If the holding register is empty, or rx_valid&rx_ready in the same cycle: rx_data<=byte, rx_valid<=1 next cycle.
  - Otherwise the byte is dropped, overrun<=1, and rx_data/rx_valid are unchanged.
- Handshake:
  - rx_valid deasserts the cycle after rx_valid&rx_ready unless a new byte loads in that same cycle.
  - rx_data never changes while rx_valid=1 and rx_ready=0.
- Latency: from the spi_clk pin rising edge of bit 7 to rx_valid=1 is 3-4 clk cycles (2 sync, 1 detect/load, plus up to 1 cycle of pin-edge phase uncertainty).
- Simultaneous events:
  - rise in the same cycle as the timeout threshold: rise wins, no frame_err.
  - clr_err in the same cycle as an error set: set wins, flag stays 1.
  - Completion in the same cycle as rx_ready with rx_valid=1: accept and reload, no overrun.
- Minimum supported spi_clk half-period: 3 clk cycles; operation faster than this is undefined.
- Arithmetic:
  - bit_cnt is 3 bits; it wraps naturally 7->0 only on completion.
  - to_cnt saturates; it never wraps.

Test Plan:
- Transmit 0xA5 at 10 MHz spi_clk (5-cycle half period), rx_ready=0 -> rx_valid=1 within 4 clk of the 8th rising edge, rx_data=0xA5 held; raise rx_ready for 1 cycle -> rx_valid=0 next cycle, overrun=0, frame_err=0.
- Back-to-back 0x3C then 0xC3 with rx_ready tied 1 -> two rx_valid pulses carrying 0x3C then 0xC3, no errors.
- Send 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun=1; pulse clr_err -> overrun=0, rx_data still 0x11.
- Send 5 bits, then hold spi_clk high for 40 clk -> frame_err=1, no rx_valid; then send 0x5A -> rx_data=0x5A received intact.
- Assert rst after 4 bits of 0xF0 -> all outputs 0 immediately; release and send 0xFF -> rx_data=0xFF, no errors.
- 8th rising edge lands in the same cycle as rx_ready with 0x77 held, new byte 0x88 -> rx_valid stays 1, rx_data=0x88, overrun=0.
